// File: rtl/idct_pkg.sv
// Widths, cosine table, FSM states and fixed-point helpers shared by idct_2d and idct_dot8.
package idct_pkg;

    localparam int COEF_W  = 16;
    localparam int PIX_W   = 9;
    localparam int FRAC_W  = 12;
    localparam int MID_W   = 20;
    localparam int CONST_W = FRAC_W + 2;
    // One engine serves both passes, so it is sized for the wider column-pass operands.
    localparam int OP_W    = MID_W;
    localparam int SUM_W   = MID_W + FRAC_W + 4;

    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    typedef logic signed [CONST_W-1:0] cst_t;

    // COS_TAB[k][n] = round(2^FRAC_W * c(k)/2 * cos((2n+1)k*pi/16))
    localparam cst_t COS_TAB [8][8] = '{
        '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
        '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009},
        '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892},
        '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703},
        '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
        '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138},
        '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784},
        '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400}
    };

    localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1 << (FRAC_W - 1));
    localparam logic signed [SUM_W-1:0] MID_MAX  = SUM_W'((1 << (MID_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MID_MIN  = ~MID_MAX;
    localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'((1 << (PIX_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] PIX_MIN  = ~PIX_MAX;

    function automatic logic signed [SUM_W-1:0] round_fix(input logic signed [SUM_W-1:0] acc);
        return (acc + HALF_LSB) >>> FRAC_W;
    endfunction

    function automatic logic signed [MID_W-1:0] sat_mid(input logic signed [SUM_W-1:0] v);
        if (v > MID_MAX) return MID_MAX[MID_W-1:0];
        if (v < MID_MIN) return MID_MIN[MID_W-1:0];
        return v[MID_W-1:0];
    endfunction

    function automatic logic pix_clipped(input logic signed [SUM_W-1:0] v);
        return (v > PIX_MAX) || (v < PIX_MIN);
    endfunction

    function automatic logic signed [PIX_W-1:0] sat_pix(input logic signed [SUM_W-1:0] v);
        if (v > PIX_MAX) return PIX_MAX[PIX_W-1:0];
        if (v < PIX_MIN) return PIX_MIN[PIX_W-1:0];
        return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-term signed dot product with a full-precision sum.
module idct_dot8 #(
    parameter int OP_W  = 20,
    parameter int CST_W = 14,
    parameter int SUM_W = 36
) (
    input  logic [7:0][OP_W-1:0]    op_a_i,
    input  logic [7:0][CST_W-1:0]   cst_i,
    output logic signed [SUM_W-1:0] sum_o
);

    localparam int PROD_W = OP_W + CST_W;

    logic signed [PROD_W-1:0] prod [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mul
            logic signed [PROD_W-1:0] a_ext;
            logic signed [PROD_W-1:0] c_ext;
            assign a_ext    = PROD_W'($signed(op_a_i[gi]));
            assign c_ext    = PROD_W'($signed(cst_i[gi]));
            assign prod[gi] = a_ext * c_ext;
        end
    endgenerate

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < 8; k++) begin
            sum_o = sum_o + SUM_W'(prod[k]);
        end
    end

endmodule

// File: rtl/idct_2d.sv
// 8x8 separable inverse DCT: row pass into a transpose buffer, then column pass, one shared dot engine.
// Optional saturation counter output sat_count is enabled by defining IDCT_SAT_CNT_EN.
module idct_2d
    import idct_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_block,
    input  logic [7:0][7:0][COEF_W-1:0]     coef_block,
    output logic [7:0][7:0][PIX_W-1:0]      pix_block_out,
    output logic                            block_done,
    output logic                            busy
`ifdef IDCT_SAT_CNT_EN
    ,
    output logic [6:0]                      sat_count
`endif
);

    state_t                         state_q, state_d;
    logic [5:0]                     idx_q, idx_d;
    logic [7:0][7:0][COEF_W-1:0]    coef_q;
    logic [7:0][7:0][MID_W-1:0]     tbuf_q;
    logic [7:0][7:0][PIX_W-1:0]     stage_q, stage_d;
    logic [7:0][7:0][PIX_W-1:0]     pix_q;

    logic [2:0]                     slot_hi, slot_lo;
    logic [7:0][OP_W-1:0]           dot_a;
    logic [7:0][CONST_W-1:0]        dot_c;
    logic signed [SUM_W-1:0]        dot_sum;
    logic signed [SUM_W-1:0]        rounded;
    logic signed [MID_W-1:0]        mid_val;
    logic signed [PIX_W-1:0]        pix_val;
    logic                           last_col;

    assign slot_hi  = idx_q[5:3];
    assign slot_lo  = idx_q[2:0];
    assign last_col = (state_q == COL) && (&idx_q);

    // Row pass reads X[u][k]; column pass reads t[k][n]. The constant column is always C[k][idx[2:0]].
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ops
            assign dot_a[gi] = (state_q == COL)
                             ? tbuf_q[gi][slot_hi]
                             : {{(OP_W-COEF_W){coef_q[slot_hi][gi][COEF_W-1]}}, coef_q[slot_hi][gi]};
            assign dot_c[gi] = COS_TAB[gi][slot_lo];
        end
    endgenerate

    idct_dot8 #(
        .OP_W  (OP_W),
        .CST_W (CONST_W),
        .SUM_W (SUM_W)
    ) u_dot (
        .op_a_i (dot_a),
        .cst_i  (dot_c),
        .sum_o  (dot_sum)
    );

    assign rounded = round_fix(dot_sum);
    assign mid_val = sat_mid(rounded);
    assign pix_val = sat_pix(rounded);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_block) begin
                    state_d = ROW;
                    idx_d   = '0;
                end
            end
            ROW: begin
                idx_d = idx_q + 6'd1;
                if (&idx_q) state_d = COL;
            end
            COL: begin
                idx_d = idx_q + 6'd1;
                if (&idx_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (state_q == COL) stage_d[slot_lo][slot_hi] = pix_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Loaded on the edge into DONE so the block is visible alongside block_done.
            if (last_col) pix_q <= stage_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start_block) coef_q <= coef_block;
        if (state_q == ROW) tbuf_q[slot_hi][slot_lo] <= mid_val;
        stage_q <= stage_d;
    end

    always_comb begin
        busy       = 1'b0;
        block_done = 1'b0;
        if (state_q == ROW || state_q == COL) busy = 1'b1;
        if (state_q == DONE) block_done = 1'b1;
    end

    assign pix_block_out = pix_q;

`ifdef IDCT_SAT_CNT_EN
    logic [6:0] sat_acc_q, sat_acc_d, sat_count_q;
    logic       clip_now;

    assign clip_now  = (state_q == COL) && pix_clipped(rounded);
    assign sat_acc_d = sat_acc_q + {6'd0, clip_now};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_acc_q   <= '0;
            sat_count_q <= '0;
        end else begin
            if (state_q == IDLE) sat_acc_q <= '0;
            else if (state_q == COL) sat_acc_q <= sat_acc_d;
            if (last_col) sat_count_q <= sat_acc_d;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_idct_2d.sv
// Scoreboard bench for idct_2d: directed DC/timing/reset cases plus random blocks vs a matrix-level model.
module tb_idct_2d;

    localparam int COEF_W = 16;
    localparam int PIX_W  = 9;

    typedef logic [7:0][7:0][COEF_W-1:0] blk_t;
    typedef logic [7:0][7:0][PIX_W-1:0]  pblk_t;

    typedef struct {
        pblk_t pix;
        int    sat;
        int    done_cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start_block;
    blk_t  coef_block;
    pblk_t pix_block_out;
    logic  block_done;
    logic  busy;
`ifdef IDCT_SAT_CNT_EN
    logic [6:0] sat_count;
`endif

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    cmat [8][8];
    exp_t  sb [$];
    exp_t  mon_e;
    pblk_t last_push_pix;
    pblk_t held_pix;
    int    t_start;

    idct_2d dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_block   (start_block),
        .coef_block    (coef_block),
        .pix_block_out (pix_block_out),
        .block_done    (block_done),
        .busy          (busy)
`ifdef IDCT_SAT_CNT_EN
        ,
        .sat_count     (sat_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint rnd(input longint s);
        return (s + 2048) >>> 12;
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Straight matrix form: T = R(X*C) clipped to 20 bits, P = R(C^T*T) clipped to pixel range.
    function automatic void ref_idct(input blk_t x, output pblk_t p, output int sat);
        longint t [8][8];
        longint s;
        sat = 0;
        for (int u = 0; u < 8; u++) begin
            for (int n = 0; n < 8; n++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += longint'($signed(x[u][k])) * longint'(cmat[k][n]);
                t[u][n] = clamp(rnd(s), -524288, 524287);
            end
        end
        for (int n = 0; n < 8; n++) begin
            for (int y = 0; y < 8; y++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += t[k][n] * longint'(cmat[k][y]);
                s = rnd(s);
                if (s > 255 || s < -256) sat++;
                s = clamp(s, -256, 255);
                p[y][n] = PIX_W'(s);
            end
        end
    endfunction

    function automatic blk_t dc_block(input int v);
        blk_t b;
        b = '0;
        b[0][0] = COEF_W'(v);
        return b;
    endfunction

    function automatic blk_t rand_block();
        blk_t b;
        int   cls;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                cls = int'($urandom_range(0, 9));
                if (cls < 4)       b[u][v] = '0;
                else if (cls < 7)  b[u][v] = COEF_W'(int'($urandom_range(0, 255)) - 128);
                else if (cls < 9)  b[u][v] = COEF_W'(int'($urandom_range(0, 4095)) - 2048);
                else               b[u][v] = COEF_W'($urandom);
            end
        end
        return b;
    endfunction

    task automatic issue(input blk_t b, input bit accepted);
        exp_t e;
        start_block = 1'b1;
        coef_block  = b;
        t_start     = cyc;
        if (accepted) begin
            ref_idct(b, e.pix, e.sat);
            e.done_cyc    = cyc + 129;
            last_push_pix = e.pix;
            sb.push_back(e);
        end
        tick();
        start_block = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", sb.size());
            sb.delete();
        end
        held_pix = last_push_pix;
    endtask

    task automatic check_uniform(input string name, input int v);
        int bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (int'($signed(pix_block_out[y][x])) != v) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d pixels differ, pixel[0][0] got %0d expected %0d",
                     name, bad, $signed(pix_block_out[0][0]), v);
        end
    endtask

    // Monitor: every block_done pops one expectation and compares timing and data.
    always @(negedge clk) begin
        if (block_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done_cycle", cyc, -1);
            end else begin
                int bad;
                int fy;
                int fx;
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                bad = 0;
                fy  = 0;
                fx  = 0;
                for (int y = 0; y < 8; y++) begin
                    for (int x = 0; x < 8; x++) begin
                        if (pix_block_out[y][x] !== mon_e.pix[y][x]) begin
                            if (bad == 0) begin
                                fy = y;
                                fx = x;
                            end
                            bad++;
                        end
                    end
                end
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL block_pixels: %0d of 64 differ, first [%0d][%0d] got %0d expected %0d",
                             bad, fy, fx, $signed(pix_block_out[fy][fx]), $signed(mon_e.pix[fy][fx]));
                end
`ifdef IDCT_SAT_CNT_EN
                check("sat_count", sat_count, mon_e.sat);
`endif
            end
        end
    end

    initial begin
        real cval;
        int  bad_busy;

        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                cval = 4096.0 * ((k == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0
                     * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
                cmat[k][n] = $rtoi($floor(cval + 0.5));
            end
        end

        rst_n       = 1'b0;
        start_block = 1'b0;
        coef_block  = '0;
        repeat (3) tick();
        check("reset_pix_zero", (pix_block_out === '0), 1);
        check("reset_busy", busy, 0);
        check("reset_done", block_done, 0);
`ifdef IDCT_SAT_CNT_EN
        check("reset_sat_count", sat_count, 0);
`endif
        rst_n = 1'b1;
        tick();

        // All-zero block with cycle-exact busy window
        check("busy_before_start", busy, 0);
        issue('0, 1'b1);
        bad_busy = 0;
        for (int c = 1; c <= 130; c++) begin
            if (busy !== ((c <= 128) ? 1'b1 : 1'b0)) bad_busy++;
            tick();
        end
        check("busy_window_errors", bad_busy, 0);
        wait_drain();
        check_uniform("zero_block", 0);

        issue(dc_block(1024), 1'b1);
        wait_drain();
        check_uniform("dc_1024", 128);

        issue(dc_block(-2048), 1'b1);
        wait_drain();
        check_uniform("dc_m2048", -256);

        issue(dc_block(4000), 1'b1);
        wait_drain();
        check_uniform("dc_4000", 255);

        // Start while busy is ignored; output holds until the next DONE
        issue(rand_block(), 1'b1);
        repeat (9) tick();
        check("pix_hold_while_busy", (pix_block_out === held_pix), 1);
        issue(dc_block(1024), 1'b0);
        wait_drain();
        check("restart_offset", cyc - t_start, 120);
        issue(dc_block(1024), 1'b1);
        wait_drain();
        check_uniform("after_ignored_start", 128);

        // Reset in the middle of a block
        issue(rand_block(), 1'b1);
        repeat (39) tick();
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        check("midrst_pix_zero", (pix_block_out === '0), 1);
        check("midrst_busy", busy, 0);
        repeat (4) tick();
        issue(rand_block(), 1'b1);
        wait_drain();

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            issue(rand_block(), 1'b1);
            wait_drain();
        end

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_2d.md
Name: idct_2d

Overview:
- 8x8 two-dimensional inverse DCT for the decoder path. It is the counterpart of dct_2d.
- Accepts one dequantized coefficient block on a start_block pulse and returns a block of signed pixels, level-shifted like the dct_2d input.
- Separable: a row pass, then a column pass, through one shared 8-tap dot-product engine and an internal transpose buffer.
- Sits between the dequantizer and the pixel writer in the hardware decoder.

Parameters:
- COEF_W, 16: signed coefficient input width.
- PIX_W, 9: signed pixel output width.
- FRAC_W, 12: fraction bits of the cosine constants.
- MID_W, 20: signed width of the row-pass intermediate held in the transpose buffer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_block  in  1  one-cycle request; block is sampled in the same cycle.
- coef_block  in  COEF_W x[7:0][7:0]  signed coefficients, indexed [u][v].
- pix_block_out  out  PIX_W x[7:0][7:0]  signed pixels, indexed [y][x].
- block_done  out  1  one-cycle pulse; pix_block_out is valid from this cycle.
- busy  out  1  high from the cycle after the accepted start until block_done.

Behaviour:
Reset:
- clk is the only clock; rst_n is synchronous and active-low.
- On reset: pix_block_out is all 0, block_done=0, busy=0, state=IDLE, indices=0.
- Reset mid-operation aborts the block. No block_done is produced.

Constants:
- C[k][n] = round(2^FRAC_W * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt(2) and c(k>0)=1.
- For example, C[0][n] = 1448.

Rounding (R):
- Add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.

FSM (IDLE, ROW, COL, DONE):
- IDLE:
  - start_block=1 at cycle T: capture coef_block into the input register, set busy=1, go to ROW with idx=0.
- ROW (cycles T+1..T+64):
  - idx[5:3]=row u, idx[2:0]=output n.
  - t[u][n] = R(sum_k X[u][k]*C[k][n]), saturated to MID_W and written to the transpose buffer.
- COL (cycles T+65..T+128):
  - idx[5:3]=column n, idx[2:0]=output y.
  - p[y][n] = R(sum_k t[k][n]*C[k][y]), saturated to [-2^(PIX_W-1), 2^(PIX_W-1)-1].
  - Results are written to a staging buffer.
- DONE (cycle T+129):
  - Copy the staging buffer to pix_block_out.
  - block_done=1 and busy=0 for exactly this cycle; next state IDLE.
- Latency: block_done occurs 129 cycles after the start cycle. The next start is accepted in cycle T+130.

Start handling:
- pix_block_out changes only in the DONE cycle and holds its value until the next DONE.
- start_block while busy or in DONE is ignored: no queueing and no restart.
- start_block and reset in the same cycle: reset wins.

Arithmetic widths:
- Product widths are full precision.
- Sums use COEF_W+FRAC_W+4 bits in the row pass and MID_W+FRAC_W+4 bits in the column pass, so no internal overflow occurs before the saturation stage.

Optional Feature:
- Macro IDCT_SAT_CNT_EN.
- When defined: an extra output port sat_count (out, 7 bits).
  - It holds the number of column-pass samples clipped to the pixel range in the last completed block (range 0..64).
  - It updates in the DONE cycle and resets to 0.
  - Row-pass MID_W saturation is not counted.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package idct_pkg holds:
  - width localparams (defaults above);
  - an 8x8 cosine constant array;
  - state typedef enum {IDLE, ROW, COL, DONE};
  - the rounding/saturation helper functions.
- One sub-module, idct_dot8: a combinational 8-term signed dot product.
  - Inputs: eight operands of parameterized width and eight constants.
  - Output: a full-width sum.
  - Instantiated once in idct_2d and shared by both passes through operand muxing.

Test Plan:
- All-zero block, start at cycle T:
  - busy high on T+1..T+128; block_done on T+129 only.
  - All pixels 0.
- DC only, X[0][0]=1024:
  - Row pass gives t[0][n]=362.
  - All 64 pixels = 128; sat_count=0.
- DC only, X[0][0]=-2048:
  - All pixels = -256 (boundary, not clipped); sat_count=0.
- DC only, X[0][0]=4000:
  - All pixels = 255; sat_count=64 (with IDCT_SAT_CNT_EN).
- Second start_block at T+10 with a different block:
  - Ignored; first result is unchanged at T+129.
  - New start at T+130 gives block_done at T+259.
- rst_n=0 at T+40 for one cycle:
  - No block_done; pix_block_out=0 and busy=0 from T+41.
  - Fresh start at T+45 gives block_done at T+174 with correct data.
